// File: rtl/floating_point_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : floating_point_mul_pipe
//  Purpose  : Pipelined IEEE 754 binary floating-point multiplier with
//             valid/ready handshakes. Round-to-nearest-even, flush-to-zero on
//             subnormal inputs and results, canonical quiet NaN, and
//             underflow / overflow / invalid flags.
//  Revision : 1.0 - initial release
// ============================================================================
//  Pipeline (four register levels, all frozen together on output stall):
//    S0 : operand capture register (accept edge)
//    S1 : unpack - sign, biased exponent sum, operand classification
//    S2 : full-width mantissa multiply
//    S3 : normalise, round, apply special-case priority, pack (output regs)
//  Operands accepted at edge N appear on the outputs after edge N+3.
// ============================================================================
module floating_point_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [EXP_W+MAN_W:0]   y,
    output logic                   u_flow,
    output logic                   o_flow,
    output logic                   nv,
    output logic                   out_valid,
    input  logic                   out_ready
);

    // ------------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------------
    localparam int c_W   = 1 + EXP_W + MAN_W;    // word width
    localparam int c_EXW = EXP_W + 2;            // signed working exponent
    localparam int c_MW  = MAN_W + 1;            // mantissa with hidden bit
    localparam int c_PW  = 2 * MAN_W + 2;        // full product width

    localparam logic [c_EXW-1:0] c_BIAS = {3'b000, {(EXP_W-1){1'b1}}};
    localparam logic [c_EXW-1:0] c_EMAX = {2'b00, {EXP_W{1'b1}}};
    localparam logic [EXP_W-1:0] c_EXP_ONES = {EXP_W{1'b1}};
    localparam logic [c_W-1:0]   c_QNAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // ------------------------------------------------------------------------
    // Handshake: a held output freezes every stage (no bubble collapse), so
    // upstream readiness is simply the inverse of the output stall.
    // ------------------------------------------------------------------------
    logic w_stall;
    logic w_adv;

    assign w_stall  = out_valid & ~out_ready;
    assign w_adv    = ~w_stall;
    assign in_ready = w_adv;

    // ------------------------------------------------------------------------
    // S0 : operand capture
    // ------------------------------------------------------------------------
    logic             r_s0_valid;
    logic [c_W-1:0]   r_s0_a;
    logic [c_W-1:0]   r_s0_b;

    // Capture operands on accept; a bubble enters when in_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0_valid <= 1'b0;
            r_s0_a     <= '0;
            r_s0_b     <= '0;
        end else if (w_adv) begin
            r_s0_valid <= in_valid;
            if (in_valid) begin
                r_s0_a <= a;
                r_s0_b <= b;
            end
        end
    end

    // ------------------------------------------------------------------------
    // S1 : unpack and classify
    // ------------------------------------------------------------------------
    logic [EXP_W-1:0] w_ea;
    logic [EXP_W-1:0] w_eb;
    logic [MAN_W-1:0] w_fa;
    logic [MAN_W-1:0] w_fb;
    logic             w_a_zero;
    logic             w_b_zero;
    logic             w_a_inf;
    logic             w_b_inf;
    logic             w_a_nan;
    logic             w_b_nan;
    logic [c_EXW-1:0] w_esum;

    assign w_ea = r_s0_a[c_W-2 -: EXP_W];
    assign w_eb = r_s0_b[c_W-2 -: EXP_W];
    assign w_fa = r_s0_a[MAN_W-1:0];
    assign w_fb = r_s0_b[MAN_W-1:0];

    // A zero exponent field covers both true zero and subnormals; the latter
    // are flushed to a signed zero here.
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_a_inf  = (w_ea == c_EXP_ONES) && (w_fa == '0);
    assign w_b_inf  = (w_eb == c_EXP_ONES) && (w_fb == '0);
    assign w_a_nan  = (w_ea == c_EXP_ONES) && (w_fa != '0);
    assign w_b_nan  = (w_eb == c_EXP_ONES) && (w_fb != '0);

    // Biased exponent of the unnormalised product, two's complement.
    assign w_esum = {2'b00, w_ea} + {2'b00, w_eb} - c_BIAS;

    logic             r_s1_valid;
    logic             r_s1_sign;
    logic [c_EXW-1:0] r_s1_exp;
    logic [c_MW-1:0]  r_s1_ma;
    logic [c_MW-1:0]  r_s1_mb;
    logic             r_s1_nv;
    logic             r_s1_inf;
    logic             r_s1_zero;

    // Register unpacked operands and their collapsed special-case class.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_exp   <= '0;
            r_s1_ma    <= '0;
            r_s1_mb    <= '0;
            r_s1_nv    <= 1'b0;
            r_s1_inf   <= 1'b0;
            r_s1_zero  <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= r_s0_valid;
            if (r_s0_valid) begin
                r_s1_sign <= r_s0_a[c_W-1] ^ r_s0_b[c_W-1];
                r_s1_exp  <= w_esum;
                r_s1_ma   <= {1'b1, w_fa};
                r_s1_mb   <= {1'b1, w_fb};
                r_s1_nv   <= w_a_nan | w_b_nan |
                             (w_a_inf & w_b_zero) | (w_a_zero & w_b_inf);
                r_s1_inf  <= w_a_inf | w_b_inf;
                r_s1_zero <= w_a_zero | w_b_zero;
            end
        end
    end

    // ------------------------------------------------------------------------
    // S2 : mantissa multiply
    // ------------------------------------------------------------------------
    logic [c_PW-1:0]  w_prod;

    assign w_prod = {{(c_PW-c_MW){1'b0}}, r_s1_ma} *
                    {{(c_PW-c_MW){1'b0}}, r_s1_mb};

    logic             r_s2_valid;
    logic             r_s2_sign;
    logic [c_EXW-1:0] r_s2_exp;
    logic [c_PW-1:0]  r_s2_prod;
    logic             r_s2_nv;
    logic             r_s2_inf;
    logic             r_s2_zero;

    // Register the full product; class and exponent ride alongside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_sign  <= 1'b0;
            r_s2_exp   <= '0;
            r_s2_prod  <= '0;
            r_s2_nv    <= 1'b0;
            r_s2_inf   <= 1'b0;
            r_s2_zero  <= 1'b0;
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_sign <= r_s1_sign;
                r_s2_exp  <= r_s1_exp;
                r_s2_prod <= w_prod;
                r_s2_nv   <= r_s1_nv;
                r_s2_inf  <= r_s1_inf;
                r_s2_zero <= r_s1_zero;
            end
        end
    end

    // ------------------------------------------------------------------------
    // S3 : normalise, round to nearest even, pack
    // ------------------------------------------------------------------------
    // The product of two [1,2) mantissas lies in [1,4); its top bit tells
    // whether one extra right shift is needed.
    logic             w_hi;
    logic [c_MW-1:0]  w_mant;
    logic             w_guard;
    logic             w_sticky;
    logic             w_inc;
    logic [c_MW:0]    w_mant_r;
    logic             w_rcarry;
    logic [MAN_W-1:0] w_frac;
    logic [c_EXW-1:0] w_exp_f;
    logic             w_ovf;
    logic             w_unf;

    assign w_hi     = r_s2_prod[c_PW-1];
    assign w_mant   = w_hi ? r_s2_prod[c_PW-1 -: c_MW] : r_s2_prod[c_PW-2 -: c_MW];
    assign w_guard  = w_hi ? r_s2_prod[MAN_W] : r_s2_prod[MAN_W-1];
    assign w_sticky = w_hi ? (|r_s2_prod[MAN_W-1:0]) : (|r_s2_prod[MAN_W-2:0]);

    // Round up above the halfway point, or exactly at it when lsb is odd.
    assign w_inc    = w_guard & (w_sticky | w_mant[0]);
    assign w_mant_r = {1'b0, w_mant} + {{c_MW{1'b0}}, w_inc};

    // A carry out of the rounded mantissa means it became exactly 2.0; the
    // renormalised fraction is then all zeros.
    assign w_rcarry = w_mant_r[c_MW];
    assign w_frac   = w_rcarry ? w_mant_r[MAN_W:1] : w_mant_r[MAN_W-1:0];

    assign w_exp_f  = r_s2_exp
                    + {{(c_EXW-1){1'b0}}, w_hi}
                    + {{(c_EXW-1){1'b0}}, w_rcarry};

    assign w_ovf    = ($signed(w_exp_f) >= $signed(c_EMAX));
    assign w_unf    = w_exp_f[c_EXW-1] | (w_exp_f == '0);

    logic [c_W-1:0]   w_y_nxt;
    logic             w_uf_nxt;
    logic             w_of_nxt;
    logic             w_nv_nxt;

    // Special-case priority: NaN/invalid, infinity, zero, overflow,
    // underflow, then the ordinary packed result. At most one flag results.
    always_comb begin
        w_y_nxt  = {r_s2_sign, w_exp_f[EXP_W-1:0], w_frac};
        w_uf_nxt = 1'b0;
        w_of_nxt = 1'b0;
        w_nv_nxt = 1'b0;
        if (r_s2_nv) begin
            w_y_nxt  = c_QNAN;
            w_nv_nxt = 1'b1;
        end else if (r_s2_inf) begin
            w_y_nxt  = {r_s2_sign, c_EXP_ONES, {MAN_W{1'b0}}};
        end else if (r_s2_zero) begin
            w_y_nxt  = {r_s2_sign, {(c_W-1){1'b0}}};
        end else if (w_ovf) begin
            w_y_nxt  = {r_s2_sign, c_EXP_ONES, {MAN_W{1'b0}}};
            w_of_nxt = 1'b1;
        end else if (w_unf) begin
            w_y_nxt  = {r_s2_sign, {(c_W-1){1'b0}}};
            w_uf_nxt = 1'b1;
        end
    end

    logic             r_out_valid;
    logic [c_W-1:0]   r_y;
    logic             r_uf;
    logic             r_of;
    logic             r_nv;

    // Output register; holds result and flags stable while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_uf        <= 1'b0;
            r_of        <= 1'b0;
            r_nv        <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_y  <= w_y_nxt;
                r_uf <= w_uf_nxt;
                r_of <= w_of_nxt;
                r_nv <= w_nv_nxt;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign u_flow    = r_uf;
    assign o_flow    = r_of;
    assign nv        = r_nv;

endmodule
`default_nettype wire
